// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: LEGv8 opcode constants, bubble word,
// FSM state and the RAW scoreboard entry.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h8b1f03ff;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam logic [4:0]  XZR = 5'd31;

    typedef enum logic {RUN, BR_WAIT} state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] r;
    } sb_entry_t;

    // XZR reads are constant zero, so they can never depend on a writer.
    function automatic logic src_hit(input logic v, input logic [4:0] r,
                                     input sb_entry_t a, input sb_entry_t b);
        return v && (r != XZR) && ((a.v && a.r == r) || (b.v && b.r == r));
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational register-usage decode of a fetched LEGv8 word.
module instr_class_dec
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic        has_dest,
    output logic [4:0]  dest,
    output logic        src_a_v,
    output logic [4:0]  src_a,
    output logic        src_b_v,
    output logic [4:0]  src_b,
    output logic        is_cbz
);

    logic [10:0] op;
    logic        unused_bits;

    assign op          = instr[31:21];
    assign unused_bits = ^instr[15:10];

    always_comb begin
        has_dest = 1'b0;
        dest     = instr[4:0];
        src_a_v  = 1'b0;
        src_a    = instr[9:5];
        src_b_v  = 1'b0;
        src_b    = instr[20:16];
        is_cbz   = 1'b0;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            has_dest = 1'b1;
            src_a_v  = 1'b1;
            src_b_v  = 1'b1;
        end else if (op == OP_LDUR) begin
            has_dest = 1'b1;
            src_a_v  = 1'b1;
        end else if (op == OP_STUR) begin
            src_a_v  = 1'b1;
            src_b_v  = 1'b1;
            src_b    = instr[4:0];
        end else if (op[10:3] == OP_CBZ) begin
            src_a_v  = 1'b1;
            src_a    = instr[4:0];
            is_cbz   = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_scheduler.sv
// Fetch-stage controller: owns the PC, loads IF/ID and inserts hardware bubbles
// for RAW hazards against the two youngest writers and for the CBZ shadow.
//
//   state   | meaning
//   RUN     | fetching; bubble only on a RAW hazard
//   BR_WAIT | CBZ issued; bubble every cycle until br_resolve
module fetch_scheduler
    import fetch_pkg::*;
#(
    parameter int            N   = 32,
    parameter int            PCW = 64,
    parameter logic [N-1:0]  NOP = NOP_INSTR
) (
    input  logic           clk,
    input  logic           reset,
    output logic [6:0]     imem_addr,
    input  logic [N-1:0]   imem_q,
    input  logic           br_resolve,
    input  logic           br_taken,
    input  logic [PCW-1:0] br_target,
    output logic [N-1:0]   ifid_instr,
    output logic [PCW-1:0] ifid_pc,
    output logic           ifid_valid,
    output logic [15:0]    stall_cnt
);

    state_t         state;
    logic [PCW-1:0] pc;
    sb_entry_t      d1, d2;

    logic           has_dest, src_a_v, src_b_v, is_cbz, hazard;
    logic [4:0]     dest, src_a, src_b;

    instr_class_dec u_dec (
        .instr    (imem_q[31:0]),
        .has_dest (has_dest),
        .dest     (dest),
        .src_a_v  (src_a_v),
        .src_a    (src_a),
        .src_b_v  (src_b_v),
        .src_b    (src_b),
        .is_cbz   (is_cbz)
    );

    assign imem_addr = pc[8:2];

    always_comb begin
        hazard = src_hit(src_a_v, src_a, d1, d2) || src_hit(src_b_v, src_b, d1, d2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= '0;
            d1         <= '0;
            d2         <= '0;
            ifid_instr <= NOP;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            d2      <= d1;
            ifid_pc <= pc;
            if (state == RUN && !hazard) begin
                ifid_instr <= imem_q;
                ifid_valid <= 1'b1;
                pc         <= pc + PCW'(4);
                d1         <= '{v: has_dest && (dest != XZR), r: dest};
                if (is_cbz)
                    state <= BR_WAIT;
            end else begin
                ifid_instr <= NOP;
                ifid_valid <= 1'b0;
                d1         <= '0;
                if (stall_cnt != 16'hFFFF)
                    stall_cnt <= stall_cnt + 16'd1;
                // PC already points past the CBZ, so not-taken just resumes.
                if (state == BR_WAIT && br_resolve) begin
                    if (br_taken)
                        pc <= br_target;
                    state <= RUN;
                end
            end
        end
    end

    a_no_resolve_in_run: assert property (
        @(posedge clk) disable iff (reset) !(br_resolve && state == RUN)
    );

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: directed scenarios followed by random
// programs, all compared against a behavioural pipeline model.
module tb_fetch_scheduler;

    localparam logic [31:0] NOPW = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic        br_resolve = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic        ifid_valid;
    logic [15:0] stall_cnt;

    logic [31:0] rom [128];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [63:0] m_pc;
    bit          m_wait;
    int          m_d1, m_d2;
    logic [31:0] m_instr;
    bit          m_valid;
    logic [63:0] m_ifpc;
    int          m_cnt;

    fetch_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_q     (imem_q),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid),
        .stall_cnt  (stall_cnt)
    );

    assign imem_q = rom[imem_addr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [10:0] op, input int rm, input int rn, input int rd);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction

    function automatic logic [31:0] ldur(input int rt, input int rn);
        return {11'b11111000010, 9'd0, 2'b00, 5'(rn), 5'(rt)};
    endfunction

    function automatic logic [31:0] stur(input int rt, input int rn);
        return {11'b11111000000, 9'd0, 2'b00, 5'(rn), 5'(rt)};
    endfunction

    function automatic logic [31:0] cbz(input int rt);
        return {8'hB4, 19'd2, 5'(rt)};
    endfunction

    // Register usage of a word; -1 means "none", XZR is dropped entirely.
    function automatic void classify(input logic [31:0] w, output int s1, output int s2,
                                     output int d, output bit is_br);
        s1 = -1; s2 = -1; d = -1; is_br = 0;
        case (w[31:21])
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                s1 = int'(w[9:5]); s2 = int'(w[20:16]); d = int'(w[4:0]);
            end
            11'b11111000010: begin s1 = int'(w[9:5]); d = int'(w[4:0]); end
            11'b11111000000: begin s1 = int'(w[9:5]); s2 = int'(w[4:0]); end
            default: if (w[31:24] == 8'hB4) begin s1 = int'(w[4:0]); is_br = 1; end
        endcase
        if (s1 == 31) s1 = -1;
        if (s2 == 31) s2 = -1;
        if (d == 31)  d  = -1;
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] q, input logic res,
                              input logic tk, input logic [63:0] tgt);
        int s1, s2, d;
        bit is_br, hz;
        if (rst) begin
            m_pc = 0; m_wait = 0; m_d1 = -1; m_d2 = -1;
            m_instr = NOPW; m_valid = 0; m_ifpc = 0; m_cnt = 0;
        end else begin
            classify(q, s1, s2, d, is_br);
            hz = (s1 >= 0 && (s1 == m_d1 || s1 == m_d2)) ||
                 (s2 >= 0 && (s2 == m_d1 || s2 == m_d2));
            m_d2 = m_d1;
            if (m_wait || hz) begin
                m_instr = NOPW; m_valid = 0; m_d1 = -1;
                if (m_cnt < 65535) m_cnt++;
                if (m_wait && res) begin
                    if (tk) m_pc = tgt;
                    m_wait = 0;
                end
            end else begin
                m_instr = q; m_valid = 1; m_ifpc = m_pc;
                m_pc = m_pc + 64'd4; m_d1 = d; m_wait = is_br;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic res, input logic tk, input logic [63:0] tgt);
        @(negedge clk);
        reset = rst; br_resolve = res; br_taken = tk; br_target = tgt;
        #1;
        if (!rst) check_eq("imem_addr", 64'(imem_addr), 64'(m_pc[8:2]));
        model_step(rst, rom[m_pc[8:2]], res, tk, tgt);
        @(posedge clk);
        #1;
        check_eq("ifid_valid", 64'(ifid_valid), 64'(m_valid));
        check_eq("ifid_instr", 64'(ifid_instr), 64'(m_instr));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (m_valid || rst) check_eq("ifid_pc", ifid_pc, m_valid ? m_ifpc : 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 9);
        int a = $urandom_range(0, 4);
        int b = $urandom_range(0, 4);
        int c = $urandom_range(0, 4);
        if (a == 4) a = 31;
        if (b == 4) b = 31;
        if (c == 4) c = 31;
        case (k)
            0: return r_type(11'b10001011000, a, b, c);
            1: return r_type(11'b11001011000, a, b, c);
            2: return r_type(11'b10001010000, a, b, c);
            3: return r_type(11'b10101010000, a, b, c);
            4, 5: return ldur(a, b);
            6: return stur(a, b);
            7: return cbz(a);
            8: return NOPW;
            default: return {11'd0, 21'($urandom)};
        endcase
    endfunction

    logic [31:0] seq [4];
    logic [31:0] add1, add2, ld, add3;

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = NOPW;
        add1 = r_type(11'b10001011000, 0, 5, 3);
        add2 = r_type(11'b10001011000, 3, 3, 4);
        ld   = ldur(12, 0);
        add3 = r_type(11'b10001011000, 31, 12, 7);
        rom[0] = add1; rom[1] = add2;
        rom[2] = ld;   rom[3] = NOPW; rom[4] = add3;
        rom[64] = cbz(0);

        cycle(1, 0, 0, 0);
        check_eq("reset_valid", 64'(ifid_valid), 64'd0);
        check_eq("reset_instr", 64'(ifid_instr), 64'(NOPW));
        check_eq("reset_addr", 64'(imem_addr), 64'd0);
        check_eq("reset_cnt", 64'(stall_cnt), 64'd0);

        // back-to-back dependency: two bubbles
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            seq[i] = ifid_instr;
            if (i == 1 || i == 2) check_eq("raw1_pc_hold", 64'(imem_addr), 64'd1);
        end
        check_eq("raw1_seq0", 64'(seq[0]), 64'(add1));
        check_eq("raw1_seq1", 64'(seq[1]), 64'(NOPW));
        check_eq("raw1_seq2", 64'(seq[2]), 64'(NOPW));
        check_eq("raw1_seq3", 64'(seq[3]), 64'(add2));
        check_eq("raw1_cnt", 64'(stall_cnt), 64'd2);

        // distance-2 dependency: one bubble
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        check_eq("raw2_instr", 64'(ifid_instr), 64'(add3));
        check_eq("raw2_pc", ifid_pc, 64'h10);
        check_eq("raw2_cnt", 64'(stall_cnt), 64'd3);

        // XZR-only stream up to the CBZ at 0x100
        for (int i = 0; i < 59; i++) cycle(0, 0, 0, 0);
        check_eq("xzr_cnt", 64'(stall_cnt), 64'd3);
        check_eq("cbz_addr", 64'(imem_addr), 64'd64);

        // CBZ taken to 0xF8 with resolve three cycles after issue
        cycle(0, 0, 0, 0);
        check_eq("cbz_issue_pc", ifid_pc, 64'h100);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 64'hF8);
        check_eq("cbz_bubbles", 64'(stall_cnt), 64'd6);
        cycle(0, 0, 0, 0);
        check_eq("taken_pc", ifid_pc, 64'hF8);
        check_eq("taken_valid", 64'(ifid_valid), 64'd1);

        // same CBZ, not taken this time
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 64'hF8);
        cycle(0, 0, 0, 0);
        check_eq("not_taken_pc", ifid_pc, 64'h104);

        // run to 0x1FC and wrap the ROM address
        for (int i = 0; i < 62; i++) cycle(0, 0, 0, 0);
        check_eq("wrap_last_pc", ifid_pc, 64'h1FC);
        check_eq("wrap_addr", 64'(imem_addr), 64'd0);

        // counter saturation
        rom[0] = cbz(0);
        rom[1] = cbz(1);
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFE;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check_eq("sat_cnt", 64'(stall_cnt), 64'hFFFF);

        // reset in BR_WAIT with a resolve pending
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 64'h80);
        check_eq("rst_bw_valid", 64'(ifid_valid), 64'd0);
        check_eq("rst_bw_addr", 64'(imem_addr), 64'd0);
        check_eq("rst_bw_cnt", 64'(stall_cnt), 64'd0);
        cycle(0, 0, 0, 0);
        check_eq("rst_bw_first_pc", ifid_pc, 64'd0);
        check_eq("rst_bw_first_valid", 64'(ifid_valid), 64'd1);

        // random programs, resolves and occasional resets
        for (int i = 0; i < 128; i++) rom[i] = rand_instr();
        for (int i = 0; i < 3000; i++) begin
            logic r, res, tk;
            logic [63:0] tgt;
            r = ($urandom_range(0, 299) == 0);
            res = 0; tk = 0; tgt = 0;
            if (m_wait && $urandom_range(0, 2) == 0) begin
                res = 1;
                tk  = 1'($urandom_range(0, 1));
                tgt = {$urandom, $urandom} & ~64'h3;
            end
            if (i % 500 == 499) rom[$urandom_range(0, 127)] = rand_instr();
            cycle(r, res, tk, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
